bf_phase_sched: RTL

//  Top-level sequencer for the arbitrage graph engine. Runs one Bellman-Ford evaluation per start:

---
 rtl/hft_sched_pkg.sv | 28 ++
 rtl/bf_phase_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hft_sched_pkg.sv
// Shared types and constants for the Bellman-Ford phase scheduler.
// Vertex count is fixed at 8.
package hft_sched_pkg;

  localparam int SCHED_NODES = 8;

  localparam int ENG_INIT  = 0;
  localparam int ENG_RELAX = 1;
  localparam int ENG_CYCLE = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST,
    S_INIT,
    S_RELAX,
    S_RELAX_NEXT,
    S_CYCLE,
    S_FINISH
  } sched_state_t;

  typedef enum logic [1:0] {
    OWN_HOST  = 2'd0,
    OWN_INIT  = 2'd1,
    OWN_RELAX = 2'd2,
    OWN_CYCLE = 2'd3
  } mem_owner_t;

endpackage

// File: rtl/bf_phase_sched.sv
// Sequencer: INIT -> NODES-1 RELAX passes -> CYCLE, owning the memory muxes.
// Optional RELAX_EARLY_EXIT_EN: a pass with no update ends the run early.
module bf_phase_sched
    import hft_sched_pkg::*;
#(
    parameter int NODES  = SCHED_NODES,
    parameter int PASS_W = $clog2(NODES),
    parameter int OVR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              host_req,
    output logic              host_gnt,
    output logic [2:0]        eng_reset,
    input  logic [2:0]        eng_done,
    input  logic              relax_changed,
    output logic [1:0]        mem_sel,
    output logic              busy,
    output logic              run_done,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NODES - 2);

    sched_state_t      state;
    sched_state_t      state_n;
    mem_owner_t        owner;
    logic [1:0]        settle;
    logic              done_ok;
    logic              start_pend;
    logic              pend_n;
    logic              ovr_inc;
    logic [PASS_W-1:0] pass_n;

`ifdef RELAX_EARLY_EXIT_EN
    logic chg_q;
    logic chg_n;
`else
    logic relax_unused;
    assign relax_unused = relax_changed;
`endif

    // Done is trusted only from the 2nd cycle after an engine leaves reset.
    assign done_ok = (settle == 2'd2);
    assign mem_sel = owner;

    always_comb begin
        state_n   = state;
        pend_n    = start_pend;
        ovr_inc   = 1'b0;
        pass_n    = pass_cnt;
`ifdef RELAX_EARLY_EXIT_EN
        chg_n     = chg_q;
`endif
        eng_reset = 3'b111;
        owner     = OWN_HOST;
        host_gnt  = 1'b0;
        busy      = 1'b0;
        run_done  = 1'b0;

        if (start) begin
            pend_n  = 1'b1;
            ovr_inc = start_pend;
        end

        case (state)
            S_IDLE: begin
                if (host_req) begin
                    state_n = S_HOST;
                end else if (start || start_pend) begin
                    state_n = S_INIT;
                    pend_n  = start && start_pend;
                    ovr_inc = 1'b0;
                end
            end
            S_HOST: begin
                host_gnt = 1'b1;
                if (!host_req) state_n = S_IDLE;
            end
            S_INIT: begin
                busy                = 1'b1;
                eng_reset[ENG_INIT] = 1'b0;
                owner               = OWN_INIT;
                if (done_ok && eng_done[ENG_INIT]) begin
                    state_n = S_RELAX;
                    pass_n  = '0;
                end
            end
            S_RELAX: begin
                busy                 = 1'b1;
                eng_reset[ENG_RELAX] = 1'b0;
                owner                = OWN_RELAX;
                if (done_ok && eng_done[ENG_RELAX]) begin
                    state_n = S_RELAX_NEXT;
`ifdef RELAX_EARLY_EXIT_EN
                    chg_n   = relax_changed;
`endif
                end
            end
            S_RELAX_NEXT: begin
                busy  = 1'b1;
                owner = OWN_RELAX;
`ifdef RELAX_EARLY_EXIT_EN
                if (!chg_q) begin
                    state_n = S_FINISH;
                end else
`endif
                if (pass_cnt == LAST_PASS) begin
                    state_n = S_CYCLE;
                end else begin
                    state_n = S_RELAX;
                    pass_n  = pass_cnt + PASS_W'(1);
                end
            end
            S_CYCLE: begin
                busy                 = 1'b1;
                eng_reset[ENG_CYCLE] = 1'b0;
                owner                = OWN_CYCLE;
                if (done_ok && eng_done[ENG_CYCLE]) state_n = S_FINISH;
            end
            S_FINISH: begin
                busy     = 1'b1;
                run_done = 1'b1;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            settle      <= 2'd0;
            pass_cnt    <= '0;
            start_pend  <= 1'b0;
            overrun_cnt <= '0;
`ifdef RELAX_EARLY_EXIT_EN
            chg_q       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            pass_cnt   <= pass_n;
            start_pend <= pend_n;
`ifdef RELAX_EARLY_EXIT_EN
            chg_q      <= chg_n;
`endif
            if (state_n != state) begin
                settle <= 2'd0;
            end else if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (ovr_inc && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVR_W'(1);
            end
        end
    end

endmodule
